// File: rtl/cod_mapa_scan.sv
// rtl/cod_mapa_scan.sv - row-by-row 7x5 glyph matrix scanner and 3-bit encoder
module cod_mapa_scan #(
   parameter int           SETTLE    = 1,
   parameter logic [279:0] PAT_TABLE = 280'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  col_in,
   output logic [6:0]  row_sel,
   output logic        busy,
   output logic        done,
   output logic [2:0]  code,
   output logic        match,
   output logic [34:0] frame
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      CMP
   } state_t;

   state_t       state;
   logic [2:0]   row;
   logic [3:0]   cnt;
   logic [34:0]  shadow;
   logic [2:0]   hit_code;
   logic         hit;

   // Parallel compare of the captured frame against every table entry;
   // walking from the top down leaves the lowest matching index in hit_code.
   always_comb begin
      hit      = 1'b0;
      hit_code = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (shadow == PAT_TABLE[35*k +: 35]) begin
            hit      = 1'b1;
            hit_code = 3'(k);
         end
      end
   end

   // Scan sequencer: selects each row, waits SETTLE cycles, captures the
   // columns, then spends one cycle comparing and publishing the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         row     <= 3'd0;
         cnt     <= 4'd0;
         shadow  <= 35'd0;
         row_sel <= 7'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         code    <= 3'd0;
         match   <= 1'b0;
         frame   <= 35'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               row_sel <= 7'd0;
               busy    <= 1'b0;
               if (start) begin
                  state   <= SCAN;
                  row     <= 3'd0;
                  cnt     <= 4'd0;
                  row_sel <= 7'h01;
                  busy    <= 1'b1;
               end
            end
            SCAN: begin
               busy <= 1'b1;
               if (cnt != 4'(SETTLE)) begin
                  cnt <= cnt + 4'd1;
               end else begin
                  shadow[5*row +: 5] <= col_in;
                  cnt                <= 4'd0;
                  if (row == 3'd6) begin
                     state   <= CMP;
                     row     <= 3'd0;
                     row_sel <= 7'd0;
                  end else begin
                     row     <= row + 3'd1;
                     row_sel <= row_sel << 1;
                  end
               end
            end
            CMP: begin
               frame   <= shadow;
               code    <= hit ? hit_code : 3'd0;
               match   <= hit;
               done    <= 1'b1;
               busy    <= 1'b0;
               row_sel <= 7'd0;
               state   <= IDLE;
            end
            default: begin
               state   <= IDLE;
               row_sel <= 7'd0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cod_mapa_scan.sv
// tb/tb_cod_mapa_scan.sv - scoreboard bench for cod_mapa_scan with two parameter sets
module tb_cod_mapa_scan;

   localparam int S0 = 1;
   localparam int S1 = 0;

   function automatic logic [279:0] mk_tbl0();
      logic [279:0] t;
      t = '0;
      for (int k = 0; k < 8; k++) t[35*k +: 35] = 35'h1 << (4*k);
      return t;
   endfunction

   localparam logic [34:0] E2 = 35'h5_5555_AAAA;
   localparam logic [279:0] TBL0 = mk_tbl0();
   localparam logic [279:0] TBL1 = {35'h3_1415_9265, E2, 35'h0_0000_0000, 35'h7_0000_0001,
                                    35'h2_0F0F_0F0F, E2, 35'h0_ABCD_EF01, 35'h1_2345_6789};

   typedef struct {
      int          a;
      logic [2:0]  code;
      logic        match;
      logic [34:0] frame;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [34:0] mat = 35'd0;
   logic [4:0]  cin [2];
   logic [6:0]  rs [2];
   logic        busy_o [2];
   logic        done_o [2];
   logic [2:0]  code_o [2];
   logic        match_o [2];
   logic [34:0] frame_o [2];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int last_a [2] = '{-1000, -1000};
   sb_t q0[$];
   sb_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cod_mapa_scan #(.SETTLE(S0), .PAT_TABLE(TBL0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .col_in(cin[0]), .row_sel(rs[0]),
      .busy(busy_o[0]), .done(done_o[0]), .code(code_o[0]), .match(match_o[0]), .frame(frame_o[0]));

   cod_mapa_scan #(.SETTLE(S1), .PAT_TABLE(TBL1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .col_in(cin[1]), .row_sel(rs[1]),
      .busy(busy_o[1]), .done(done_o[1]), .code(code_o[1]), .match(match_o[1]), .frame(frame_o[1]));

   // Matrix model: the selected row presents its slice of mat; otherwise junk.
   always_comb begin
      for (int d = 0; d < 2; d++) begin
         cin[d] = 5'h15;
         for (int r = 0; r < 7; r++)
            if (rs[d][r]) cin[d] = mat[5*r +: 5];
      end
   end

   function automatic int lat_of(input int d);
      return 7 * (((d == 0) ? S0 : S1) + 1) + 1;
   endfunction

   function automatic logic [3:0] lookup(input logic [279:0] tbl, input logic [34:0] f);
      for (int k = 0; k < 8; k++)
         if (tbl[35*k +: 35] == f) return {1'b1, 3'(k)};
      return 4'd0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flush_model();
      q0.delete();
      q1.delete();
      last_a[0] = -1000;
      last_a[1] = -1000;
   endtask

   // Issue a one-cycle start; the model decides which DUT accepts it.
   task automatic pulse_start();
      int a;
      sb_t e;
      logic [3:0] r;
      a = cyc + 1;
      start = 1'b1;
      for (int d = 0; d < 2; d++) begin
         if (a >= last_a[d] + lat_of(d) + 1) begin
            r = lookup((d == 0) ? TBL0 : TBL1, mat);
            e.a = a;
            e.code = r[2:0];
            e.match = r[3];
            e.frame = mat;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            last_a[d] = a;
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("wait_idle_timeout", 64'(n), 64'(0));
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_rs%0d", tag, d), 64'(rs[d]), 64'(0));
         chk($sformatf("%s_busy%0d", tag, d), 64'(busy_o[d]), 64'(0));
         chk($sformatf("%s_done%0d", tag, d), 64'(done_o[d]), 64'(0));
         chk($sformatf("%s_code%0d", tag, d), 64'(code_o[d]), 64'(0));
         chk($sformatf("%s_match%0d", tag, d), 64'(match_o[d]), 64'(0));
         chk($sformatf("%s_frame%0d", tag, d), 64'(frame_o[d]), 64'(0));
      end
   endtask

   // Monitor: derives expected row_sel/busy/done from the scan timeline of
   // the oldest pending request and checks the result at the done cycle.
   always @(negedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            sb_t h;
            bit have;
            int t, L, S;
            logic [6:0] ers;
            S = (d == 0) ? S0 : S1;
            L = lat_of(d);
            have = 1'b0;
            if (d == 0 && q0.size() > 0) begin h = q0[0]; have = 1'b1; end
            if (d == 1 && q1.size() > 0) begin h = q1[0]; have = 1'b1; end
            if (have && cyc >= h.a && cyc < h.a + L) begin
               t = cyc - h.a;
               ers = (t < L - 1) ? 7'(1 << (t / (S + 1))) : 7'd0;
               chk($sformatf("scan_busy%0d", d), 64'(busy_o[d]), 64'(1));
               chk($sformatf("scan_rs%0d", d), 64'(rs[d]), 64'(ers));
               chk($sformatf("scan_done%0d", d), 64'(done_o[d]), 64'(0));
            end else if (have && cyc == h.a + L) begin
               chk($sformatf("done%0d", d), 64'(done_o[d]), 64'(1));
               chk($sformatf("done_busy%0d", d), 64'(busy_o[d]), 64'(0));
               chk($sformatf("done_rs%0d", d), 64'(rs[d]), 64'(0));
               chk($sformatf("code%0d", d), 64'(code_o[d]), 64'(h.code));
               chk($sformatf("match%0d", d), 64'(match_o[d]), 64'(h.match));
               chk($sformatf("frame%0d", d), 64'(frame_o[d]), 64'(h.frame));
               if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end else begin
               chk($sformatf("idle_done%0d", d), 64'(done_o[d]), 64'(0));
               chk($sformatf("idle_busy%0d", d), 64'(busy_o[d]), 64'(0));
               chk($sformatf("idle_rs%0d", d), 64'(rs[d]), 64'(0));
            end
         end
      end
   end

   initial begin
      int n;
      logic [63:0] r64;
      // power-on reset, asserted mid-cycle
      #2 rst = 1'b1;
      #1 chk_zero("por");
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // row walk on both parameter sets with glyph 5 of table 0
      mat = TBL0[35*5 +: 35];
      pulse_start();
      wait_idle();
      chk("t3_code5", 64'(code_o[0]), 64'(5));
      chk("t3_frame5", 64'(frame_o[0]), 64'(35'h0_0010_0000));

      // asynchronous reset with non-zero outputs present
      #2 rst = 1'b1;
      #1 chk_zero("arst");
      flush_model();
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);

      // sweep every table 0 entry
      for (int k = 0; k < 8; k++) begin
         mat = TBL0[35*k +: 35];
         pulse_start();
         wait_idle();
         chk("sweep_code", 64'(code_o[0]), 64'(k));
         chk("sweep_match", 64'(match_o[0]), 64'(1));
      end

      // miss and duplicate entry
      mat = 35'h7_FFFF_FFFF;
      pulse_start();
      wait_idle();
      chk("miss_match", 64'(match_o[0]), 64'(0));
      chk("miss_frame", 64'(frame_o[0]), 64'(35'h7_FFFF_FFFF));
      mat = E2;
      pulse_start();
      wait_idle();
      chk("dup_code", 64'(code_o[1]), 64'(2));
      chk("dup_match", 64'(match_o[1]), 64'(1));

      // start while busy, then start in the done cycle
      mat = TBL0[35*3 +: 35];
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_start();
      repeat (5) @(negedge clk);
      pulse_start();
      n = 0;
      while (!done_o[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("done_wait_timeout", 64'(n), 64'(0));
      pulse_start();
      wait_idle();

      // reset in the middle of a scan
      mat = TBL1[35*4 +: 35];
      pulse_start();
      n = 0;
      while (rs[0] != 7'h08 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("row3_wait_timeout", 64'(n), 64'(0));
      #2 rst = 1'b1;
      #1;
      chk("mid_rs0", 64'(rs[0]), 64'(0));
      chk("mid_busy0", 64'(busy_o[0]), 64'(0));
      flush_model();
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      pulse_start();
      wait_idle();
      chk("post_rst_code1", 64'(code_o[1]), 64'(4));

      // randomized frames: table hits on either side or random patterns
      for (int i = 0; i < 16; i++) begin
         r64 = {$urandom, $urandom};
         case ($urandom_range(0, 2))
            0: mat = TBL0[35*$urandom_range(0, 7) +: 35];
            1: mat = TBL1[35*$urandom_range(0, 7) +: 35];
            default: mat = r64[34:0];
         endcase
         repeat ($urandom_range(0, 3)) @(negedge clk);
         pulse_start();
         wait_idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
